// File: rtl/slt_pkg.sv
// Shared types and sizing helpers for the multi-cycle set-on-less-than unit.
package slt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  localparam logic RESULT_PAD_BIT = 1'b0;

endpackage

// File: rtl/slt_chunk_cmp.sv
// Combinational unsigned compare of one operand chunk.
module slt_chunk_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o,
  output logic         eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/slt_seq_compare.sv
// Multi-cycle slt/sltu: walks operand chunks MSB-first, stopping at the first
// differing chunk, and returns the zero-extended less-than flag.
module slt_seq_compare
  import slt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] a_cmp, b_cmp;
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic             chunk_lt, chunk_eq;

  // Biasing the sign bit turns a two's-complement order into an unsigned one.
  assign a_cmp = signed_q ? (a_q ^ SIGN_MASK) : a_q;
  assign b_cmp = signed_q ? (b_q ^ SIGN_MASK) : b_q;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunk[gi] = a_cmp[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_cmp[gi*CHUNK +: CHUNK];
  end

  slt_chunk_cmp #(
    .W(CHUNK)
  ) u_chunk_cmp (
    .a_i (a_chunk[idx_q]),
    .b_i (b_chunk[idx_q]),
    .lt_o(chunk_lt),
    .eq_o(chunk_eq)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    lt_d     = lt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          idx_d    = IDX_TOP;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (!chunk_eq) begin
          lt_d    = chunk_lt;
          state_d = DONE;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= IDX_TOP;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      lt_q     <= lt_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = {{(WIDTH-1){RESULT_PAD_BIT}}, lt_q};

endmodule

// File: doc/slt_seq_compare.md
Name: slt_seq_compare

Overview:
- Parametrised, multi-cycle set-on-less-than unit for the MIPS32 datapath.
- Compares two WIDTH-bit operands, signed (slt/slti) or unsigned (sltu/sltiu).
- Compares CHUNK bits per cycle from the MSB chunk downward and stops at the first differing chunk.
- Returns the 1-bit outcome zero-extended to WIDTH bits, ready for the register-file write-back mux. Uses a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK (≥1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- is_signed  input  1  1 = two's-complement compare (slt), 0 = unsigned (sltu); sampled with start.
- a  input  WIDTH  left operand; sampled with start.
- b  input  WIDTH  right operand; sampled with start.
- busy  output  1  high in CMP and DONE states.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  {(WIDTH-1)'b0, a<b}; held until next accepted start.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, chunk index=NCHUNK-1, operand registers=0.
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset asserted mid-operation aborts the compare in the same edge and restores all reset values; no done is issued for the aborted request.
- IDLE:
  - start=1 latches a, b and is_signed, sets idx=NCHUNK-1 and goes to CMP.
  - start=0 holds state.
- CMP: each cycle compares chunk idx of the latched operands.
  - Signed mode: the sign bit (bit WIDTH-1) of both operands is inverted before comparing. This affects only the top chunk, so an unsigned chunk compare gives the signed result.
  - Chunk a < chunk b: lt=1, go to DONE.
  - Chunk a > chunk b: lt=0, go to DONE.
  - Chunks equal and idx>0: idx decrements, stay in CMP.
  - Chunks equal and idx==0: lt=0 (operands equal), go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
  - result[0]=lt and result[WIDTH-1:1]=0 are registered on entry to DONE.
  - result persists through IDLE until the next decision.
- Latency: start accepted at edge T; CMP occupies T+1..T+k, where k = 1 + (NCHUNK-1-idx of the deciding chunk). done is high in cycle T+k+1.
  - Minimum 2 cycles (top chunk decides).
  - Maximum NCHUNK+1 cycles (equal operands, or bottom chunk decides).
- start asserted while busy=1 is ignored; it is neither queued nor allowed to alter the latched operands.
- start asserted in the same cycle as done: ignored, since the state is DONE. It is accepted one cycle later, from IDLE.
- Input changes on a, b or is_signed after acceptance have no effect.
- NCHUNK=1 degenerates to a fixed 2-cycle latency.
- result bits [WIDTH-1:1] are constant 0 in all states.

Decomposition:
- Shared package slt_pkg:
  - state enum {IDLE, CMP, DONE}
  - a localparam helper for NCHUNK and the idx width, $clog2(NCHUNK) with a minimum of 1
  - the zero-extend constant for result.
- One sub-module, slt_chunk_cmp: combinational CHUNK-bit compare producing lt and eq.
- The top level holds the FSM, operand registers, index counter, sign-flip and result register.

Test Plan (WIDTH=32, CHUNK=8, start accepted at edge T):
- Unsigned, top chunk decides: a=0x00000001, b=0x80000000, is_signed=0 → done in cycle T+2, result=0x00000001.
- Signed, top chunk decides: same operands with is_signed=1 → done in cycle T+2, result=0x00000000. Then a=0xFFFFFFFF, b=0x00000000, signed → result=0x00000001; unsigned → result=0x00000000.
- Lower chunk decides: a=0x000000FF, b=0x00000100, unsigned → done in cycle T+4, result=0x00000001. busy is high T+1..T+4.
- Equal operands: a=b=0x12345678, either mode → done in cycle T+5, result=0x00000000.
- Start while busy:
  - Issue a=5, b=3 unsigned.
  - At T+1 pulse start with a=1, b=2.
  - The second request is ignored: done occurs once, result=0x00000000.
  - A subsequent start from IDLE is accepted normally.
- Reset mid-operation: a=b=0xAAAAAAAA, reset at T+2 → the next cycle shows busy=0, done=0, result=0. No done pulse follows; a fresh start completes normally.
